vx_reset_sequencer: RTL and testbench

VX_RESET_SEQUENCER -- requirements
Module: VX_reset_sequencer

---
 rtl/vx_reset_sequencer_pkg.sv | 17 +
 rtl/vx_reset_sequencer.sv | 148 ++++++++++++++
 tb/tb_vx_reset_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_reset_sequencer_pkg.sv
// Shared helpers for the reset sequencer.
// - max3    : largest of three unsigned values, used to size the phase counter
// - log2up  : ceil(log2(n)), but never less than 1, used to size the stage index
package vx_reset_sequencer_pkg;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_reset_sequencer.sv
// Staggered multi-domain reset sequencer.
// After the input reset falls (or a req_i pulse), all domains are held in reset for
// HOLD_CYCLES, then released one at a time from index 0 upward, RELEASE_GAP cycles
// apart. The block then waits for every domain's done flag; it reports ready_o, or
// fault_o if TIMEOUT cycles pass first (TIMEOUT = 0 waits forever).
// Ports:
//   clk      - clock
//   reset    - synchronous active-high reset, takes priority over req_i
//   req_i    - single-cycle request to rerun the whole sequence
//   done_i   - per-domain init-complete flags, only honoured once the domain is released
//   reset_o  - per-domain active-high resets (registered)
//   ready_o  - all domains released and done (registered)
//   fault_o  - sticky done-wait timeout (registered)
module vx_reset_sequencer
  import vx_reset_sequencer_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned RELEASE_GAP = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_i,
  input  logic [N-1:0] done_i,
  output logic [N-1:0] reset_o,
  output logic         ready_o,
  output logic         fault_o
);

  localparam int unsigned CntW = $clog2(max3(HOLD_CYCLES, RELEASE_GAP, TIMEOUT) + 1);
  localparam int unsigned IdxW = log2up(N);

  localparam logic [CntW-1:0] CntOne      = CntW'(1);
  localparam logic [CntW-1:0] CntSat      = {CntW{1'b1}};
  localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad     = CntW'(RELEASE_GAP - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT);
  localparam logic [IdxW-1:0] IdxOne      = IdxW'(1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(N - 1);

  typedef enum logic [2:0] {
    StAssert,
    StRelease,
    StWaitDone,
    StReady,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;    // shared hold / gap / timeout counter
  logic [IdxW-1:0] idx_q, idx_d;    // next domain to release
  logic [N-1:0]    rst_q, rst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic            all_done;

  // A domain still held in reset cannot vouch for itself.
  assign all_done = &(done_i & ~rst_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;

    if (req_i) begin
      state_d = StAssert;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
    end else begin
      unique case (state_q)
        // Hold counts up from zero so reset/req leave it cleared; gap and timeout
        // phases load the counter and count down to zero.
        StAssert: begin
          if (cnt_q == HoldLast) begin
            rst_d[0] = 1'b0;
            if (N == 1) begin
              state_d = StWaitDone;
              cnt_d   = TimeoutLoad;
            end else begin
              state_d = StRelease;
              cnt_d   = GapLoad;
              idx_d   = IdxOne;
            end
          end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRelease: begin
          if (cnt_q == '0) begin
            rst_d[idx_q] = 1'b0;
            if (idx_q == IdxLast) begin
              state_d = StWaitDone;
              cnt_d   = TimeoutLoad;
            end else begin
              idx_d = idx_q + IdxOne;
              cnt_d = GapLoad;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StWaitDone: begin
          // Done is checked first so it wins a tie with timeout expiry.
          if (all_done) begin
            state_d = StReady;
          end else if ((TIMEOUT != 0) && (cnt_q == '0)) begin
            state_d = StFault;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StReady, StFault: begin
          // Terminal until reset or req_i.
        end
        default: state_d = StAssert;
      endcase
    end

    ready_d = (state_d == StReady);
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign reset_o = rst_q;
  assign ready_o = ready_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_vx_reset_sequencer.sv
// Directed bench for vx_reset_sequencer with N=4, HOLD_CYCLES=8, RELEASE_GAP=3, TIMEOUT=20.
// "Cycle c" is the value seen just after edge c-1; inputs set at cycle c are sampled at
// edge c, where edge 0 is the first edge with reset low.
module tb_vx_reset_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 3;
  localparam int TO   = 20;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic         req_i  = 1'b0;
  logic [N-1:0] done_i = '0;
  logic [N-1:0] reset_o;
  logic         ready_o;
  logic         fault_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_reset_sequencer #(
    .N          (N),
    .HOLD_CYCLES(HOLD),
    .RELEASE_GAP(GAP),
    .TIMEOUT    (TO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req_i),
    .done_i (done_i),
    .reset_o(reset_o),
    .ready_o(ready_o),
    .fault_o(fault_o)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected per-domain reset at cycle c: domain k falls at HOLD + GAP*k.
  function automatic logic [N-1:0] exp_rst(input int c);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (c < HOLD + GAP * k);
    return r;
  endfunction

  // Reset for a few cycles and leave the bench at cycle 0.
  task automatic start_seq();
    reset  = 1'b1;
    req_i  = 1'b0;
    done_i = '0;
    step(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    req_i  = 1'b1;   // reset must override req_i
    done_i = '1;
    step(3);
    checks++;
    if (reset_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_reset_o: got %h expected %h", reset_o, 4'hF);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_o: got %b expected 0", ready_o);
    end
    checks++;
    if (fault_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault_o: got %b expected 0", fault_o);
    end
    req_i  = 1'b0;
    done_i = '0;
  endtask

  // Starts at cycle 0 with done_i low; done_i goes high at cycle 20.
  task automatic run_nominal(input string tag);
    logic [N-1:0] er;
    logic         erdy;
    for (int c = 0; c <= 24; c++) begin
      if (c == 20) done_i = '1;
      er   = exp_rst(c);
      erdy = (c >= 21);
      checks++;
      if (reset_o !== er) begin
        errors++;
        $display("FAIL %s_reset_o c=%0d: got %h expected %h", tag, c, reset_o, er);
      end
      checks++;
      if (ready_o !== erdy) begin
        errors++;
        $display("FAIL %s_ready_o c=%0d: got %b expected %b", tag, c, ready_o, erdy);
      end
      checks++;
      if (fault_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_fault_o c=%0d: got %b expected 0", tag, c, fault_o);
      end
      step(1);
    end
    // Dropping done while ready must be ignored.
    done_i = '0;
    step(3);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_sticky: got %b expected 1", tag, ready_o);
    end
  endtask

  task automatic test_nominal();
    start_seq();
    run_nominal("nominal");
  endtask

  task automatic test_resequence();
    req_i = 1'b1;
    step(1);
    req_i = 1'b0;
    checks++;
    if (reset_o !== 4'hF || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reseq_pulse: got reset_o=%h ready_o=%b expected reset_o=F ready_o=0",
               reset_o, ready_o);
    end
    run_nominal("reseq");
  endtask

  task automatic test_early_done();
    logic erdy;
    start_seq();
    done_i = '1;
    for (int c = 0; c <= 22; c++) begin
      erdy = (c >= 18);
      checks++;
      if (ready_o !== erdy) begin
        errors++;
        $display("FAIL early_ready_o c=%0d: got %b expected %b", c, ready_o, erdy);
      end
      step(1);
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] er;
    logic         eflt;
    start_seq();
    done_i = 4'hB;
    for (int c = 0; c <= 45; c++) begin
      er   = exp_rst(c);
      eflt = (c >= 38);
      checks++;
      if (reset_o !== er) begin
        errors++;
        $display("FAIL timeout_reset_o c=%0d: got %h expected %h", c, reset_o, er);
      end
      checks++;
      if (fault_o !== eflt) begin
        errors++;
        $display("FAIL timeout_fault_o c=%0d: got %b expected %b", c, fault_o, eflt);
      end
      checks++;
      if (ready_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_ready_o c=%0d: got %b expected 0", c, ready_o);
      end
      step(1);
    end
  endtask

  task automatic test_collision();
    logic erdy;
    start_seq();
    for (int c = 0; c <= 40; c++) begin
      if (c == 37) done_i = '1;   // sampled on the expiry edge
      erdy = (c >= 38);
      checks++;
      if (ready_o !== erdy) begin
        errors++;
        $display("FAIL collision_ready_o c=%0d: got %b expected %b", c, ready_o, erdy);
      end
      checks++;
      if (fault_o !== 1'b0) begin
        errors++;
        $display("FAIL collision_fault_o c=%0d: got %b expected 0", c, fault_o);
      end
      step(1);
    end
    done_i = '0;
  endtask

  task automatic test_fault_clear();
    logic [N-1:0] er;
    start_seq();
    step(39);
    checks++;
    if (fault_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_set: got %b expected 1", fault_o);
    end
    req_i = 1'b1;
    step(1);
    req_i = 1'b0;
    checks++;
    if (fault_o !== 1'b0 || reset_o !== 4'hF || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: got fault=%b reset_o=%h ready=%b expected 0 F 0",
               fault_o, reset_o, ready_o);
    end
    // Hold count restarts the cycle after the pulse.
    for (int c = 0; c <= 12; c++) begin
      er = exp_rst(c);
      checks++;
      if (reset_o !== er) begin
        errors++;
        $display("FAIL fault_restart_reset_o c=%0d: got %h expected %h", c, reset_o, er);
      end
      step(1);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] er;
    start_seq();
    step(12);
    checks++;
    if (reset_o !== 4'hC) begin
      errors++;
      $display("FAIL mid_before: got %h expected %h", reset_o, 4'hC);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (reset_o !== 4'hF) begin
      errors++;
      $display("FAIL mid_reset_o: got %h expected %h", reset_o, 4'hF);
    end
    step(2);
    reset = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      er = exp_rst(c);
      checks++;
      if (reset_o !== er) begin
        errors++;
        $display("FAIL mid_restart_reset_o c=%0d: got %h expected %h", c, reset_o, er);
      end
      step(1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_resequence();
    test_early_done();
    test_timeout();
    test_collision();
    test_fault_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
